alu_regfile_pipe: RTL and testbench

//  Parametrised two-stage ALU datapath with an integrated register file: operands read by address, result written back.

---
 rtl/alu_regfile_pipe.sv | 135 +++++++++++++
 tb/tb_alu_regfile_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU execute core with an integrated register file, result forwarding
// from stage 1, and an external load/debug port.
module alu_regfile_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wb_en,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero,
  output logic              carry
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [DATA_W-1:0] regs [DEPTH];

  // Stage 1: captured op and operands
  logic              s1_valid;
  op_e               s1_op;
  logic [ADDR_W-1:0] s1_rd;
  logic              s1_wb_en;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   wide;
  logic              s1_writes;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign s1_writes = s1_valid && s1_wb_en;

  // Forward the live ALU output to a dependent op issued right behind its producer.
  assign opnd_a = (s1_writes && (s1_rd == rs1)) ? alu_res : regs[rs1];
  assign opnd_b = (s1_writes && (s1_rd == rs2)) ? alu_res : regs[rs2];

  assign read_data = regs[read_addr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alu_res   = '0;
    alu_carry = 1'b0;
    wide      = '0;
    unique case (s1_op)
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_NAND: alu_res = ~(s1_a & s1_b);
      OP_NOR:  alu_res = ~(s1_a | s1_b);
      OP_ADD: begin
        wide      = {1'b0, s1_a} + {1'b0, s1_b};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      OP_SUB: begin
        // The extra top bit of an unsigned subtract is the borrow (A < B).
        wide      = {1'b0, s1_a} - {1'b0, s1_b};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_PASS: alu_res = s1_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_op        <= OP_AND;
      s1_rd        <= '0;
      s1_wb_en     <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
      carry        <= 1'b0;
      // NOTE: the register file must clear on reset, so it is built from flops rather than an inferred RAM.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      s1_valid <= issue_valid;
      if (issue_valid) begin
        s1_op    <= op_e'(op);
        s1_rd    <= rd;
        s1_wb_en <= wb_en;
        s1_a     <= opnd_a;
        s1_b     <= opnd_b;
      end

      result_valid <= s1_valid;
      if (s1_valid) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        carry  <= alu_carry;
      end

      if (ext_we) begin
        regs[ext_addr] <= ext_data;
      end
      // Later assignment wins: writeback beats an ext write to the same address.
      if (s1_writes) begin
        regs[s1_rd] <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: stimulus pushes expected results into a
// scoreboard queue; a negedge monitor pops and compares on each result_valid.
module tb_alu_regfile_pipe;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [2:0] AND_OP  = 3'b000;
  localparam logic [2:0] OR_OP   = 3'b001;
  localparam logic [2:0] NAND_OP = 3'b010;
  localparam logic [2:0] NOR_OP  = 3'b011;
  localparam logic [2:0] ADD_OP  = 3'b100;
  localparam logic [2:0] SUB_OP  = 3'b101;
  localparam logic [2:0] XOR_OP  = 3'b110;
  localparam logic [2:0] PASS_OP = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic              wb_en;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              zero;
  logic              carry;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] res;
    logic              z;
    logic              c;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_regfile_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .op(op),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wb_en(wb_en),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .read_addr(read_addr), .read_data(read_data),
    .result(result), .result_valid(result_valid), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    ext_we      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic ext_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ext_we   = 1'b1;
    ext_addr = a;
    ext_data = d;
    tick();
    ext_we   = 1'b0;
  endtask

  // Drives one issue for a cycle; issue_valid stays high so ops can go back-to-back.
  task automatic issue(input string name, input logic [2:0] o, input logic [ADDR_W-1:0] d,
                       input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic w,
                       input logic [DATA_W-1:0] er, input logic ez, input logic ec,
                       input bit expect_result = 1'b1);
    exp_t e;
    issue_valid = 1'b1;
    op = o; rd = d; rs1 = a; rs2 = b; wb_en = w;
    if (expect_result) begin
      e.name = name; e.res = er; e.z = ez; e.c = ec;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic read_reg(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    read_addr = a;
    #1;
    check(name, read_data, exp);
  endtask

  // Monitor: compares every result_valid pulse against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result_valid: got pulse with result 0x%0h, expected none", result);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_zero"},   zero,   e.z);
          check({e.name, "_carry"},  carry,  e.c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; wb_en = 1'b0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; read_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_zero", zero, 1'b0);
    check("rst_carry", carry, 1'b0);
    for (int i = 0; i < 8; i++) read_reg($sformatf("rst_reg%0d", i), ADDR_W'(i), 8'h00);

    // 1. AND with writeback
    ext_write(3'd1, 8'h95);
    ext_write(3'd2, 8'hCC);
    read_reg("ext_r1", 3'd1, 8'h95);
    issue("and", AND_OP, 3'd3, 3'd1, 3'd2, 1'b1, 8'h84, 1'b0, 1'b0);
    idle(2);
    read_reg("wb_r3", 3'd3, 8'h84);

    // 2. Back-to-back ADD then dependent SUB
    issue("add_fwd", ADD_OP, 3'd4, 3'd1, 3'd2, 1'b1, 8'h61, 1'b0, 1'b1);
    issue("sub_fwd", SUB_OP, 3'd5, 3'd4, 3'd4, 1'b1, 8'h00, 1'b1, 1'b0);
    idle(3);
    read_reg("wb_r4", 3'd4, 8'h61);
    read_reg("wb_r5", 3'd5, 8'h00);

    // 3. Logic ops, no writeback
    issue("nand", NAND_OP, 3'd0, 3'd1, 3'd2, 1'b0, 8'h7B, 1'b0, 1'b0);
    issue("nor",  NOR_OP,  3'd0, 3'd1, 3'd2, 1'b0, 8'h22, 1'b0, 1'b0);
    issue("xor",  XOR_OP,  3'd0, 3'd1, 3'd2, 1'b0, 8'h59, 1'b0, 1'b0);
    issue("pass", PASS_OP, 3'd0, 3'd1, 3'd2, 1'b0, 8'h95, 1'b0, 1'b0);
    issue("or",   OR_OP,   3'd0, 3'd1, 3'd2, 1'b0, 8'hDD, 1'b0, 1'b0);

    // 4. Subtract borrow and add overflow
    issue("sub_nb", SUB_OP, 3'd0, 3'd2, 3'd1, 1'b0, 8'h37, 1'b0, 1'b0);
    issue("sub_b",  SUB_OP, 3'd0, 3'd1, 3'd2, 1'b0, 8'hC9, 1'b0, 1'b1);
    idle(1);
    ext_write(3'd6, 8'hFF);
    ext_write(3'd7, 8'h01);
    issue("add_ovf", ADD_OP, 3'd0, 3'd6, 3'd7, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(3);

    // Forwarding into rs2 then rs1 with non-zero values
    issue("add_r5",  ADD_OP,  3'd5, 3'd1, 3'd7, 1'b1, 8'h96, 1'b0, 1'b0);
    issue("xor_fb",  XOR_OP,  3'd5, 3'd2, 3'd5, 1'b1, 8'h5A, 1'b0, 1'b0);
    issue("pass_fa", PASS_OP, 3'd4, 3'd5, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0);
    idle(3);
    read_reg("fwd_r4", 3'd4, 8'h5A);

    // wb_en=0 producer must not forward
    issue("add_nowb",  ADD_OP,  3'd1, 3'd1, 3'd1, 1'b0, 8'h2A, 1'b0, 1'b1);
    issue("pass_nofw", PASS_OP, 3'd0, 3'd1, 3'd0, 1'b0, 8'h95, 1'b0, 1'b0);
    idle(3);
    read_reg("nowb_r1", 3'd1, 8'h95);

    // Ext write and issue in same cycle: old value captured
    ext_we = 1'b1; ext_addr = 3'd7; ext_data = 8'h10;
    issue("pass_extold", PASS_OP, 3'd0, 3'd7, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0);
    idle(3);
    read_reg("ext_r7", 3'd7, 8'h10);

    // 6. Writeback and ext write on the same edge, same and different addresses
    issue("and_r7", AND_OP, 3'd7, 3'd1, 3'd2, 1'b1, 8'h84, 1'b0, 1'b0);
    issue_valid = 1'b0;
    ext_write(3'd7, 8'hAA);
    idle(2);
    read_reg("collide_r7", 3'd7, 8'h84);
    issue("and_r6", AND_OP, 3'd6, 3'd1, 3'd2, 1'b1, 8'h84, 1'b0, 1'b0);
    issue_valid = 1'b0;
    ext_write(3'd0, 8'h3C);
    idle(2);
    read_reg("both_r6", 3'd6, 8'h84);
    read_reg("both_r0", 3'd0, 8'h3C);
    issue("or_nowb", OR_OP, 3'd3, 3'd1, 3'd2, 1'b0, 8'hDD, 1'b0, 1'b0);
    idle(3);
    read_reg("nowb_r3", 3'd3, 8'h84);

    // 5. Reset while an op sits in stage 1; issue during reset ignored
    issue("add_killed", ADD_OP, 3'd6, 3'd1, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    issue("pass_inrst", PASS_OP, 3'd2, 3'd1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(4);
    check("post_rst_result_valid", result_valid, 1'b0);
    check("post_rst_result", result, 8'h00);
    for (int i = 0; i < 8; i++) read_reg($sformatf("post_rst_reg%0d", i), ADDR_W'(i), 8'h00);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
